// File: rtl/subtractor_if.sv
// Operand/result bundle between a KPN source and the subtractor node.
// master drives the operands and observes the result; slave is the subtractor side.
interface subtractor_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] entry_1;
    logic [WIDTH-1:0] entry_2;
    logic [WIDTH-1:0] output_1;

    modport master (
        output entry_1,
        output entry_2,
        input  output_1
    );

    modport slave (
        input  entry_1,
        input  entry_2,
        output output_1
    );
endinterface

// File: rtl/subtractor.sv
// subtractor: output_1 <= entry_1 - entry_2 every edge, 1-cycle latency, no backpressure.
// SUBTRACTOR_SATURATE_EN clamps the result to 0 when entry_2 > entry_1 instead of wrapping.
module subtractor #(
    parameter int WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    subtractor_if.slave bus
);
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] result_q;

    always_comb begin
        diff = bus.entry_1 - bus.entry_2;
`ifdef SUBTRACTOR_SATURATE_EN
        if (bus.entry_2 > bus.entry_1) begin
            diff = '0;
        end
`endif
    end

    // Reset clears the register immediately, discarding any pending difference.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= '0;
        end else begin
            result_q <= diff;
        end
    end

    assign bus.output_1 = result_q;
endmodule

// File: tb/tb_subtractor.sv
// Directed bench for subtractor: literal expectations plus a per-cycle model compare.
module tb_subtractor;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fails;
    bit   check_en;
    logic [15:0] last_exp;

    // Model state: the operand pair captured at the most recent non-reset edge.
    bit          have_pair;
    logic [15:0] samp_a;
    logic [15:0] samp_b;

    subtractor_if #(.WIDTH(16)) bus ();

    subtractor #(.WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] model_diff(input logic [15:0] a, input logic [15:0] b);
        int d;
        d = int'(a) - int'(b);
`ifdef SUBTRACTOR_SATURATE_EN
        if (d < 0) d = 0;
`endif
        if (d < 0) d = d + 65536;
        return 16'(d);
    endfunction

    function automatic logic [15:0] model_out();
        return have_pair ? model_diff(samp_a, samp_b) : 16'h0000;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            have_pair = 1'b0;
        end else begin
            samp_a    = bus.entry_1;
            samp_b    = bus.entry_2;
            have_pair = 1'b1;
        end
    end

    always @(posedge reset) have_pair = 1'b0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) chk("model_compare", bus.output_1, model_out());
    end

    // Called 1ns after a rising edge: checks the old value holds until the edge, then the new one.
    task automatic apply(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp);
        bus.entry_1 = a;
        bus.entry_2 = b;
        #3;
        chk({name, "_before_edge"}, bus.output_1, last_exp);
        @(posedge clk);
        #1;
        chk(name, bus.output_1, exp);
        last_exp = exp;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        n_checks    = 0;
        n_fails     = 0;
        have_pair   = 1'b0;
        samp_a      = '0;
        samp_b      = '0;
        last_exp    = 16'h0000;
        reset       = 1'b1;
        bus.entry_1 = 16'd20;
        bus.entry_2 = 16'd10;
        #1;
        check_en = 1'b1;
        chk("reset_immediate", bus.output_1, 16'h0000);

        repeat (3) begin
            @(posedge clk);
            #1;
            chk("reset_hold", bus.output_1, 16'h0000);
        end

        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("first_after_release", bus.output_1, 16'd10);
        last_exp = 16'd10;

        apply("seq_45_10", 16'd45, 16'd10, 16'd35);
        apply("seq_90_5", 16'd90, 16'd5, 16'd85);

`ifdef SUBTRACTOR_SATURATE_EN
        apply("under_10_20", 16'd10, 16'd20, 16'h0000);
        apply("under_0_1", 16'h0000, 16'h0001, 16'h0000);
`else
        apply("under_10_20", 16'd10, 16'd20, 16'hFFF6);
        apply("under_0_1", 16'h0000, 16'h0001, 16'hFFFF);
`endif
        apply("max_minus_max", 16'hFFFF, 16'hFFFF, 16'h0000);
        apply("max_minus_zero", 16'hFFFF, 16'h0000, 16'hFFFF);
        apply("equal_mid", 16'h1234, 16'h1234, 16'h0000);
        apply("sub_zero", 16'h8001, 16'h0000, 16'h8001);
        apply("back_to_85", 16'd90, 16'd5, 16'd85);

        // Async reset pulse between edges.
        #2;
        reset = 1'b1;
        #1;
        chk("reset_async_clear", bus.output_1, 16'h0000);
        #2;
        reset = 1'b0;
        #1;
        chk("reset_stays_clear", bus.output_1, 16'h0000);
        @(posedge clk);
        #1;
        chk("after_pulse_release", bus.output_1, 16'd85);
        last_exp = 16'd85;

        // Glitch on inputs shorter than half a period, settled before the edge.
        bus.entry_1 = 16'd30;
        bus.entry_2 = 16'd5;
        #2;
        bus.entry_1 = 16'd200;
        bus.entry_2 = 16'd0;
        #2;
        chk("glitch_no_effect", bus.output_1, 16'd85);
        bus.entry_1 = 16'd30;
        bus.entry_2 = 16'd5;
        @(posedge clk);
        #1;
        chk("glitch_settled", bus.output_1, 16'd25);

        // Extra vectors checked only through the model compare.
        for (int i = 0; i < 20; i++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = (i % 3 == 0) ? ra : 16'($urandom_range(0, 65535));
            bus.entry_1 = ra;
            bus.entry_2 = rb;
            @(posedge clk);
            #1;
        end

        @(negedge clk);
        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
